// File: rtl/digits_pkg.sv
// Shared definitions for the decimal digit datapath (digits_to_number, number_of_digits).
// Holds the FSM state encoding, the BCD digit width, the decimal base and the largest legal digit.
// Has no ports; other files use it with import digits_pkg::*.
package digits_pkg;

  localparam int DIGIT_W  = 4;
  localparam int DEC_BASE = 10;
  localparam logic [DIGIT_W-1:0] MAX_BCD = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= MAX_BCD;
  endfunction

endpackage

// File: rtl/digits_to_number_if.sv
// Bundles the digits_to_number handshake and result signals.
// Producer side: start, digit, digit_valid, digit_last. Consumer side: digit_ready, value, count, done, error.
// The master modport is the digit source. The slave modport is the converter.
interface digits_to_number_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  import digits_pkg::*;

  logic                 start;
  logic [DIGIT_W-1:0]   digit;
  logic                 digit_valid;
  logic                 digit_last;
  logic                 digit_ready;
  logic [WIDTH-1:0]     value;
  logic [CNT_W-1:0]     count;
  logic                 done;
  logic                 error;

  modport master (
    output start, digit, digit_valid, digit_last,
    input  digit_ready, value, count, done, error
  );

  modport slave (
    input  start, digit, digit_valid, digit_last,
    output digit_ready, value, count, done, error
  );

endinterface

// File: rtl/mul10_add.sv
// Combinational step sum_o = acc_i*10 + digit_i, computed WIDTH+DIGIT_W bits wide.
// Ports: acc_i (WIDTH), digit_i (DIGIT_W) in. sum_o (low WIDTH bits) and ovf_o out.
// ovf_o is set when any bit above WIDTH-1 of the wide result is set.
module mul10_add
  import digits_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   acc_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [WIDTH-1:0]   sum_o,
  output logic               ovf_o
);

  logic [WIDTH+DIGIT_W-1:0] acc_ext;
  logic [WIDTH+DIGIT_W-1:0] prod;

  // acc*10 < 2^WIDTH * 16, so the widened sum cannot wrap.
  assign acc_ext = {{DIGIT_W{1'b0}}, acc_i};
  assign prod    = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit_i};
  assign sum_o   = prod[WIDTH-1:0];
  assign ovf_o   = |prod[WIDTH+DIGIT_W-1:WIDTH];

endmodule

// File: rtl/digits_to_number.sv
// Rebuilds a binary value and a digit count from a serial BCD digit stream, most significant digit first.
// Ports: clk, rst (sync, active high), bus (slave modport of digits_to_number_if).
// Optional macro DIGITS_TO_NUMBER_LZ_STRIP_EN: count only significant digits (all-zero input reports 1).
module digits_to_number
  import digits_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  digits_to_number_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_out;
  logic             err_q, err_d;
  logic             ready_q, done_q, error_q;
  logic [WIDTH-1:0] value_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] step_sum;
  logic             step_ovf;
  logic             accept;
  logic             cnt_inc;
`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
  logic             sig_q, sig_d;
`endif

  mul10_add #(.WIDTH(WIDTH)) u_mul10_add (
    .acc_i   (acc_q),
    .digit_i (bus.digit),
    .sum_o   (step_sum),
    .ovf_o   (step_ovf)
  );

  assign accept = (state_q == ACCUM) && ready_q && bus.digit_valid;

  // A digit that causes the error freezes acc as well; the value is forced to zero at DONE anyway.
  assign err_d = err_q | (accept & (~is_bcd(bus.digit) | step_ovf));
  assign acc_d = (accept && !err_d) ? step_sum : acc_q;

`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
  // Counting starts at the first non-zero digit of the number.
  assign sig_d   = sig_q | (accept && (bus.digit != '0));
  assign cnt_inc = accept && sig_d;
  assign cnt_out = (cnt_d == '0) ? CNT_ONE : cnt_d;
`else
  assign cnt_inc = accept;
  assign cnt_out = cnt_d;
`endif

  assign cnt_d = (cnt_inc && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      value_q <= '0;
      count_q <= '0;
      error_q <= 1'b0;
`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
      sig_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            value_q <= '0;
            count_q <= '0;
            error_q <= 1'b0;
`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
            sig_q   <= 1'b0;
`endif
            ready_q <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          err_q <= err_d;
`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
          sig_q <= sig_d;
`endif
          if (accept && bus.digit_last) begin
            ready_q <= 1'b0;
            done_q  <= 1'b1;
            value_q <= err_d ? '0 : acc_d;
            count_q <= cnt_out;
            error_q <= err_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.digit_ready = ready_q;
  assign bus.done        = done_q;
  assign bus.value       = value_q;
  assign bus.count       = count_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_digits_to_number.sv
// Testbench for digits_to_number: directed table, corner sequences and random streams against a reference model.
// Ports: none; drives the converter through digits_to_number_if.
// Honours DIGITS_TO_NUMBER_LZ_STRIP_EN when computing expected digit counts.
module tb_digits_to_number;
  import digits_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  digits_to_number_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  digits_to_number #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [3:0] dq[$];

  // Reference: decimal arithmetic over the whole digit list, with a wide accumulator.
  function automatic void model(output logic [WIDTH-1:0] v, output logic [CNT_W-1:0] c,
                                output logic e);
    longint unsigned acc   = 0;
    longint unsigned limit = (64'd1 << WIDTH) - 1;
    int total = 0;
    int sig   = 0;
    bit seen  = 0;
    int cmax  = (1 << CNT_W) - 1;
    int cn;
    e = 1'b0;
    foreach (dq[i]) begin
      total++;
      if (dq[i] != 0) seen = 1;
      if (seen) sig++;
      if (!e) begin
        if (dq[i] > 9) e = 1'b1;
        else begin
          acc = acc * DEC_BASE + dq[i];
          if (acc > limit) e = 1'b1;
        end
      end
    end
`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
    cn = (sig == 0) ? 1 : sig;
`else
    cn = total;
`endif
    if (cn > cmax) cn = cmax;
    c = CNT_W'(cn);
    v = e ? '0 : WIDTH'(acc);
  endfunction

  // Start a conversion, stream dq with 'gap' idle cycles before each digit, check the result.
  task automatic run_conv(input int gap, input string tag, input logic [WIDTH-1:0] ev,
                          input logic [CNT_W-1:0] ec, input logic ee);
    int w;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "/ready_latency"}, bus.digit_ready, 1);
    for (int i = 0; i < dq.size(); i++) begin
      repeat (gap) begin
        bus.digit      = 4'($urandom % 16);
        bus.digit_last = 1'($urandom % 2);
        @(negedge clk);
      end
      bus.digit       = dq[i];
      bus.digit_valid = 1'b1;
      bus.digit_last  = (i == dq.size() - 1);
      w = 0;
      while (!bus.digit_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w == 20) begin
        chk({tag, "/ready_timeout"}, 0, 1);
        break;
      end
      @(negedge clk);
      bus.digit_valid = 1'b0;
      bus.digit_last  = 1'b0;
    end
    chk({tag, "/done_latency"}, bus.done, 1);
    chk({tag, "/value"}, bus.value, ev);
    chk({tag, "/count"}, bus.count, ec);
    chk({tag, "/error"}, bus.error, ee);
    @(negedge clk);
    chk({tag, "/done_pulse"}, bus.done, 0);
  endtask

  typedef struct {
    string            name;
    logic [47:0]      d;
    int               n;
    int               gap;
    logic [WIDTH-1:0] v;
    int               c_all;
    int               c_lz;
    logic             e;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [WIDTH-1:0] mv;
    logic [CNT_W-1:0] mc;
    logic             me;
    int               ec;
    int               len;

    tbl[0] = '{"n4096",   48'h4096,        4, 0, 32'd4096,     4,  4,  1'b0};
    tbl[1] = '{"max",     48'h4294967295, 10, 0, 32'hFFFFFFFF, 10, 10, 1'b0};
    tbl[2] = '{"ovf",     48'h4294967296, 10, 0, 32'd0,        10, 10, 1'b1};
    tbl[3] = '{"bad",     48'h1A3,         3, 0, 32'd0,        3,  3,  1'b1};
    tbl[4] = '{"lz_gap",  48'h007,         3, 3, 32'd7,        3,  1,  1'b0};
    tbl[5] = '{"zeros",   48'h00,          2, 1, 32'd0,        2,  1,  1'b0};
    tbl[6] = '{"single9", 48'h9,           1, 0, 32'd9,        1,  1,  1'b0};
    tbl[7] = '{"lz_bad",  48'h0F2,         3, 0, 32'd0,        3,  2,  1'b1};
    tbl[8] = '{"drain",   48'h99999999999, 11, 2, 32'd0,       11, 11, 1'b1};

    bus.start       = 1'b0;
    bus.digit       = '0;
    bus.digit_valid = 1'b0;
    bus.digit_last  = 1'b0;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset/ready", bus.digit_ready, 0);
    chk("reset/done",  bus.done, 0);
    chk("reset/value", bus.value, 0);
    chk("reset/count", bus.count, 0);
    chk("reset/error", bus.error, 0);

    // Directed table; back-to-back starts land in the IDLE cycle right after DONE.
    foreach (tbl[k]) begin
      dq.delete();
      for (int i = 0; i < tbl[k].n; i++)
        dq.push_back(tbl[k].d[4*(tbl[k].n-1-i) +: 4]);
`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
      ec = tbl[k].c_lz;
`else
      ec = tbl[k].c_all;
`endif
      run_conv(tbl[k].gap, tbl[k].name, tbl[k].v, CNT_W'(ec), tbl[k].e);
    end

    // Results hold in IDLE.
    repeat (3) @(negedge clk);
    chk("hold/value", bus.value, 0);
    chk("hold/count", bus.count, 8'd11);
    chk("hold/error", bus.error, 1);

    // Reset mid-conversion discards progress.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.digit = 4'(i + 1); bus.digit_valid = 1'b1; bus.digit_last = 1'b0;
      @(negedge clk);
    end
    bus.digit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/ready", bus.digit_ready, 0);
    chk("midrst/value", bus.value, 0);
    chk("midrst/count", bus.count, 0);

    // Digits without a start are ignored.
    bus.digit = 4'd5; bus.digit_valid = 1'b1; bus.digit_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nostart/done", bus.done, 0);
    end
    bus.digit_valid = 1'b0; bus.digit_last = 1'b0;
    dq.delete(); dq.push_back(4'd5);
    run_conv(0, "after_rst", 32'd5, 8'd1, 1'b0);

    // start held during ACCUM has no effect.
    bus.start = 1'b1;
    @(negedge clk);
    bus.digit = 4'd3; bus.digit_valid = 1'b1; bus.digit_last = 1'b0;
    @(negedge clk);
    bus.digit_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    bus.digit = 4'd5; bus.digit_valid = 1'b1; bus.digit_last = 1'b1;
    @(negedge clk);
    bus.digit_valid = 1'b0; bus.digit_last = 1'b0;
    chk("start_in_accum/done",  bus.done, 1);
    chk("start_in_accum/value", bus.value, 32'd35);
    chk("start_in_accum/count", bus.count, 8'd2);

    // start seen in the DONE cycle is ignored.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_done/ready0", bus.digit_ready, 0);
    @(negedge clk);
    chk("start_in_done/ready1", bus.digit_ready, 0);

    // Counter saturation with 300 zero digits.
    dq.delete();
    repeat (300) dq.push_back(4'd0);
    model(mv, mc, me);
    run_conv(0, "saturate", mv, mc, me);
`ifdef DIGITS_TO_NUMBER_LZ_STRIP_EN
    chk("saturate/count_const", bus.count, 8'd1);
`else
    chk("saturate/count_const", bus.count, 8'd255);
`endif

    // Random streams against the reference model.
    for (int t = 0; t < 40; t++) begin
      dq.delete();
      len = 1 + ($urandom % 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom % 100 < 5)      dq.push_back(4'(10 + $urandom % 6));
        else if ($urandom % 4 == 0)  dq.push_back(4'd0);
        else                         dq.push_back(4'($urandom % 10));
      end
      model(mv, mc, me);
      run_conv(int'($urandom % 3), $sformatf("rand%0d", t), mv, mc, me);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
